// File: rtl/irq_sequencer_if.sv
// Core-side signal bundle of irq_sequencer: request lines, CP0 writes, boundary/eret
// strobes in; request/take handshake, vector and CP0 state out.
interface irq_sequencer_if #(
  parameter int NUM_IRQ = 3,
  parameter int ID_W    = 2
);
  logic [NUM_IRQ-1:0] in_irq;
  logic               in_boundary;
  logic               in_eret;
  logic               in_mask_we;
  logic [NUM_IRQ-1:0] in_mask_wdata;
  logic               in_ie_we;
  logic               in_ie_wdata;
  logic               out_req;
  logic               out_take;
  logic [ID_W-1:0]    out_id;
  logic [31:0]        out_vector;
  logic [NUM_IRQ-1:0] out_pending;
  logic [NUM_IRQ-1:0] out_inservice;
  logic [NUM_IRQ-1:0] out_mask;
  logic               out_ie;

  modport slave (
    input  in_irq, in_boundary, in_eret, in_mask_we, in_mask_wdata, in_ie_we, in_ie_wdata,
    output out_req, out_take, out_id, out_vector, out_pending, out_inservice, out_mask, out_ie
  );

  modport master (
    output in_irq, in_boundary, in_eret, in_mask_we, in_mask_wdata, in_ie_we, in_ie_wdata,
    input  out_req, out_take, out_id, out_vector, out_pending, out_inservice, out_mask, out_ie
  );
endinterface

// File: rtl/irq_sequencer.sv
// Nesting priority interrupt sequencer for the single-cycle MIPS core (take pulse + vector).
// Define IRQ_SYNC_EN to pass in_irq through a 2-flop synchroniser before edge detection.
module irq_sequencer #(
  parameter int          NUM_IRQ    = 3,
  parameter int          ID_W       = 2,
  parameter logic [31:0] VEC_BASE   = 32'h0000_1000,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic            in_clk,
  input  logic            in_rst_n,
  irq_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_TAKE} state_e;

  state_e             state_q;
  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] ins_q, ins_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] above;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] ins_top;
  logic               ie_q;
  logic               req_q;
  logic               take_q;
  logic               take_now;
  logic [ID_W-1:0]    sel;
  logic [ID_W-1:0]    id_q;
  logic [31:0]        vec_q;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.in_irq;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = bus.in_irq;
`endif

  assign irq_edge = irq_s & ~irq_prev_q;

  // Only sources strictly above the highest in-service level may interrupt.
  always_comb begin
    above   = '1;
    ins_top = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (ins_q[k]) begin
        ins_top = NUM_IRQ'(1) << k;
        for (int j = 0; j < NUM_IRQ; j++) above[j] = (j > k);
      end
    end
    elig = pend_q & mask_q & {NUM_IRQ{ie_q}} & above;
    sel  = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (elig[k]) sel = ID_W'(k);
    end
  end

  assign take_now = (state_q == S_REQ) && bus.in_boundary && (elig != '0);

  // eret clear precedes the take set; a fresh edge beats the take clear.
  always_comb begin
    pend_d = pend_q;
    ins_d  = ins_q;
    if (take_now) pend_d[sel] = 1'b0;
    pend_d = pend_d | irq_edge;
    if (bus.in_eret) ins_d = ins_d & ~ins_top;
    if (take_now) ins_d[sel] = 1'b1;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q    <= S_IDLE;
      irq_prev_q <= '0;
      pend_q     <= '0;
      ins_q      <= '0;
      mask_q     <= '1;
      ie_q       <= 1'b0;
      req_q      <= 1'b0;
      take_q     <= 1'b0;
      id_q       <= '0;
      vec_q      <= VEC_BASE;
    end else begin
      irq_prev_q <= irq_s;
      pend_q     <= pend_d;
      ins_q      <= ins_d;
      if (bus.in_mask_we) mask_q <= bus.in_mask_wdata;
      if (bus.in_ie_we)   ie_q   <= bus.in_ie_wdata;
      case (state_q)
        S_IDLE: begin
          if (elig != '0) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        end
        S_REQ: begin
          if (elig == '0) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end else if (bus.in_boundary) begin
            state_q <= S_TAKE;
            req_q   <= 1'b0;
            take_q  <= 1'b1;
            id_q    <= sel;
            vec_q   <= VEC_BASE + 32'(sel) * VEC_STRIDE;
          end
        end
        S_TAKE: begin
          state_q <= S_IDLE;
          take_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          take_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_req       = req_q;
  assign bus.out_take      = take_q;
  assign bus.out_id        = id_q;
  assign bus.out_vector    = vec_q;
  assign bus.out_pending   = pend_q;
  assign bus.out_inservice = ins_q;
  assign bus.out_mask      = mask_q;
  assign bus.out_ie        = ie_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed and randomized bench for irq_sequencer with a rule-level reference model.
module tb_irq_sequencer;

`ifdef IRQ_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif
  localparam int LAT = 3 + SD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irq_sequencer_if #(.NUM_IRQ(3), .ID_W(2)) bus();

  irq_sequencer #(
    .NUM_IRQ(3), .ID_W(2), .VEC_BASE(32'h0000_1000), .VEC_STRIDE(32'h0000_0010)
  ) dut (
    .in_clk(clk),
    .in_rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit [2:0]  m_pend, m_ins, m_mask, m_prev, m_s1, m_s2;
  bit        m_ie;
  int        m_phase;   // 0 waiting, 1 requesting, 2 taking
  int        m_id;
  bit [31:0] m_vec;

  function automatic int top_index(bit [2:0] v);
    int t = -1;
    for (int k = 0; k < 3; k++) if (v[k]) t = k;
    return t;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_ins = 0; m_mask = 3'b111; m_ie = 0; m_prev = 0;
    m_s1 = 0; m_s2 = 0; m_phase = 0; m_id = 0; m_vec = 32'h0000_1000;
  endtask

  task automatic model_step();
    bit [2:0] s, edge_v, npend, nins;
    int top, sel;
    s      = (SD != 0) ? m_s2 : bus.in_irq;
    edge_v = s & ~m_prev;
    top    = top_index(m_ins);
    sel    = -1;
    for (int k = 0; k < 3; k++)
      if (m_pend[k] && m_mask[k] && m_ie && k > top) sel = k;
    npend = m_pend;
    nins  = m_ins;
    if (bus.in_eret && top >= 0) nins[top] = 1'b0;
    case (m_phase)
      0: if (sel >= 0) m_phase = 1;
      1: begin
        if (sel < 0) m_phase = 0;
        else if (bus.in_boundary) begin
          m_phase    = 2;
          m_id       = sel;
          m_vec      = 32'(32'h1000 + sel * 16);
          npend[sel] = 1'b0;
          nins[sel]  = 1'b1;
        end
      end
      default: m_phase = 0;
    endcase
    npend = npend | edge_v;
    m_s2 = m_s1; m_s1 = bus.in_irq; m_prev = s;
    m_pend = npend; m_ins = nins;
    if (bus.in_mask_we) m_mask = bus.in_mask_wdata;
    if (bus.in_ie_we)   m_ie   = bus.in_ie_wdata;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("m_req",   32'(bus.out_req),       32'(m_phase == 1));
    chk("m_take",  32'(bus.out_take),      32'(m_phase == 2));
    chk("m_id",    32'(bus.out_id),        32'(m_id));
    chk("m_vec",   bus.out_vector,         m_vec);
    chk("m_pend",  32'(bus.out_pending),   32'(m_pend));
    chk("m_ins",   32'(bus.out_inservice), 32'(m_ins));
    chk("m_mask",  32'(bus.out_mask),      32'(m_mask));
    chk("m_ie",    32'(bus.out_ie),        32'(m_ie));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},  32'(bus.out_req),       32'd0);
    chk({tag, "_take"}, 32'(bus.out_take),      32'd0);
    chk({tag, "_id"},   32'(bus.out_id),        32'd0);
    chk({tag, "_vec"},  bus.out_vector,         32'h0000_1000);
    chk({tag, "_pend"}, 32'(bus.out_pending),   32'd0);
    chk({tag, "_ins"},  32'(bus.out_inservice), 32'd0);
    chk({tag, "_mask"}, 32'(bus.out_mask),      32'd7);
    chk({tag, "_ie"},   32'(bus.out_ie),        32'd0);
  endtask

  task automatic cyc();
    if (rst_n) model_step();
    else       model_reset();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic wait_take(input int bound, input int exp_id, input string tag);
    for (int i = 0; i < bound && !bus.out_take; i++) cyc();
    chk({tag, "_take"}, 32'(bus.out_take), 32'd1);
    chk({tag, "_id"},   32'(bus.out_id),   32'(exp_id));
  endtask

  task automatic drive_idle();
    bus.in_irq = 3'b000; bus.in_boundary = 1'b0; bus.in_eret = 1'b0;
    bus.in_mask_we = 1'b0; bus.in_mask_wdata = 3'b000;
    bus.in_ie_we = 1'b0; bus.in_ie_wdata = 1'b0;
  endtask

  task automatic do_eret();
    bus.in_eret = 1'b1;
    cyc();
    bus.in_eret = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    model_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    check_reset_vals("rst");
    rst_n = 1'b1;

    bus.in_ie_we = 1'b1; bus.in_ie_wdata = 1'b1;
    cyc();
    bus.in_ie_we = 1'b0;
    chk("ie_set", 32'(bus.out_ie), 32'd1);

    // basic take latency
    bus.in_boundary = 1'b1;
    bus.in_irq = 3'b010;
    for (int i = 1; i <= LAT + 1; i++) begin
      cyc();
      if (i == 1) bus.in_irq = 3'b000;
      chk("t1_take", 32'(bus.out_take), 32'(i == LAT));
      if (i == LAT) begin
        chk("t1_id",   32'(bus.out_id),        32'd1);
        chk("t1_vec",  bus.out_vector,         32'h0000_1010);
        chk("t1_pend", 32'(bus.out_pending),   32'd0);
        chk("t1_ins",  32'(bus.out_inservice), 32'b010);
      end
    end
    do_eret();
    chk("t1_eret", 32'(bus.out_inservice), 32'd0);

    // waiting for a boundary
    bus.in_boundary = 1'b0;
    bus.in_irq = 3'b001;
    cyc();
    bus.in_irq = 3'b000;
    repeat (LAT - 2) cyc();
    chk("t2_req", 32'(bus.out_req), 32'd1);
    repeat (5) begin
      cyc();
      chk("t2_notake", 32'(bus.out_take), 32'd0);
    end
    bus.in_boundary = 1'b1;
    cyc();
    chk("t2_take", 32'(bus.out_take),  32'd1);
    chk("t2_id",   32'(bus.out_id),    32'd0);
    chk("t2_vec",  bus.out_vector,     32'h0000_1000);
    do_eret();

    // nesting
    bus.in_irq = 3'b010; cyc(); bus.in_irq = 3'b000;
    wait_take(LAT + 2, 1, "n1");
    chk("n1_ins", 32'(bus.out_inservice), 32'b010);
    cyc();
    bus.in_irq = 3'b100; cyc(); bus.in_irq = 3'b000;
    wait_take(LAT + 2, 2, "n2");
    chk("n2_ins", 32'(bus.out_inservice), 32'b110);
    bus.in_irq = 3'b001; cyc(); bus.in_irq = 3'b000;
    repeat (LAT + 3) begin
      cyc();
      chk("n3_wait", 32'(bus.out_take), 32'd0);
    end
    chk("n3_pend", 32'(bus.out_pending), 32'b001);
    do_eret();
    chk("n_eret1", 32'(bus.out_inservice), 32'b010);
    repeat (4) begin
      cyc();
      chk("n3_wait2", 32'(bus.out_take), 32'd0);
    end
    do_eret();
    chk("n_eret2", 32'(bus.out_inservice), 32'b000);
    wait_take(LAT + 2, 0, "n3");
    chk("n3_ins", 32'(bus.out_inservice), 32'b001);
    cyc();
    do_eret();

    // mask drop while requesting
    bus.in_boundary = 1'b0;
    bus.in_irq = 3'b100; cyc(); bus.in_irq = 3'b000;
    repeat (LAT - 2) cyc();
    chk("m_req_on",  32'(bus.out_req),     32'd1);
    chk("m_pend_on", 32'(bus.out_pending), 32'b100);
    bus.in_mask_we = 1'b1; bus.in_mask_wdata = 3'b011;
    cyc();
    bus.in_mask_we = 1'b0;
    chk("m_mask_w", 32'(bus.out_mask), 32'b011);
    cyc();
    chk("m_req_off",  32'(bus.out_req),     32'd0);
    chk("m_pend_kept", 32'(bus.out_pending), 32'b100);
    bus.in_boundary = 1'b1;
    repeat (4) begin
      cyc();
      chk("m_notake", 32'(bus.out_take), 32'd0);
    end
    bus.in_mask_we = 1'b1; bus.in_mask_wdata = 3'b111;
    cyc();
    bus.in_mask_we = 1'b0;
    wait_take(4, 2, "m_restore");
    chk("m_pend_clr", 32'(bus.out_pending), 32'd0);
    cyc();
    do_eret();

    // new edge on the source being taken in the same cycle
    bus.in_boundary = 1'b0;
    bus.in_irq = 3'b010; cyc(); bus.in_irq = 3'b000;
    repeat (LAT - 2 - SD) cyc();
    bus.in_irq = 3'b010;
    repeat (SD) cyc();
    bus.in_boundary = 1'b1;
    cyc();
    bus.in_irq = 3'b000;
    chk("s_take", 32'(bus.out_take),      32'd1);
    chk("s_id",   32'(bus.out_id),        32'd1);
    chk("s_pend", 32'(bus.out_pending),   32'b010);
    chk("s_ins",  32'(bus.out_inservice), 32'b010);
    repeat (6) begin
      cyc();
      chk("s_blocked", 32'(bus.out_take), 32'd0);
    end
    do_eret();
    wait_take(4, 1, "s_retake");
    cyc();
    do_eret();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) bus.in_irq = 3'($urandom_range(0, 7));
      bus.in_boundary   = ($urandom_range(0, 3) != 0);
      bus.in_eret       = ($urandom_range(0, 7) == 0);
      bus.in_mask_we    = ($urandom_range(0, 29) == 0);
      bus.in_mask_wdata = 3'($urandom_range(0, 7));
      bus.in_ie_we      = ($urandom_range(0, 39) == 0);
      bus.in_ie_wdata   = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // reset while taking
    drive_idle();
    bus.in_mask_we = 1'b1; bus.in_mask_wdata = 3'b111;
    bus.in_ie_we = 1'b1; bus.in_ie_wdata = 1'b1;
    bus.in_eret = 1'b1;
    repeat (3) cyc();
    drive_idle();
    bus.in_boundary = 1'b1;
    bus.in_irq = 3'b100; cyc(); bus.in_irq = 3'b000;
    for (int i = 0; i < 20 && !bus.out_take; i++) cyc();
    chk("r_take_seen", 32'(bus.out_take), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_vals("r_async");
    check_model();
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (LAT + 3) begin
      cyc();
      chk("r_no_take", 32'(bus.out_take), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Interrupt controller for the single-cycle MIPS core. Sits beside the instruction decoder and CP0 logic.
- Captures external interrupt requests and prioritises them with nesting. Waits for an instruction boundary from the core, then issues a one-cycle take pulse with a handler vector. The core uses the pulse to save EPC and redirect the PC.
- Retires in-service levels on eret. Holds the global-enable and mask state written by mtc0.

Parameters:
- NUM_IRQ, 3, number of request lines; index NUM_IRQ-1 is highest priority.
- ID_W, 2, width of out_id; must be >= clog2(NUM_IRQ).
- VEC_BASE, 32'h0000_1000, handler address for source 0.
- VEC_STRIDE, 32'h0000_0010, address step between source vectors.

Ports:
- in_clk  input  1  system clock; all state updates on the rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_irq  input  NUM_IRQ  raw request levels; a rising edge is a request.
- in_boundary  input  1  core can accept a redirect this cycle (not a branch delay, not halted).
- in_eret  input  1  eret retiring this cycle.
- in_mask_we  input  1  write the mask register.
- in_mask_wdata  input  NUM_IRQ  new mask value (1 = enabled).
- in_ie_we  input  1  write global enable.
- in_ie_wdata  input  1  new global enable value.
- out_req  output  1  eligible interrupt waiting for a boundary.
- out_take  output  1  one-cycle redirect pulse.
- out_id  output  ID_W  id of the source being taken.
- out_vector  output  32  VEC_BASE + out_id*VEC_STRIDE; low 32 bits kept.
- out_pending  output  NUM_IRQ  pending latches.
- out_inservice  output  NUM_IRQ  in-service bits.
- out_mask  output  NUM_IRQ  mask register.
- out_ie  output  1  global enable.

Behaviour:
- Reset (async, in_rst_n low):
  - state IDLE; pending and inservice = 0; mask = all ones; ie = 0.
  - Edge-detect history = 0; out_id = 0; out_vector = VEC_BASE.
  - out_req = 0; out_take = 0.
- Reset asserted mid-REQ or mid-TAKE discards everything; no take pulse follows reset release.
- Edge detect:
  - edge = irq_s & ~irq_prev, where irq_s is in_irq (see Optional Feature).
  - An edge at sampling edge t sets pending at t; the bit is visible the following cycle.
  - Pending is sticky until taken. Masked sources still latch pending.
- Eligibility:
  - elig = pending & mask & {NUM_IRQ{ie}} & above.
  - above[k] = 1 iff k > highest set inservice index; all ones when inservice = 0.
  - sel = highest set bit of elig.
- FSM:
  - IDLE: if elig != 0, go to REQ.
  - REQ: out_req = 1.
    - If elig becomes 0 (mask or ie cleared), return to IDLE, no take.
    - If in_boundary = 1 and elig != 0: register out_id = sel and out_vector, clear pending[sel], set inservice[sel], go to TAKE.
  - TAKE: out_take = 1 for exactly one cycle, then IDLE unconditionally. Minimum 1 idle cycle between takes.
- Latency (in_boundary held high): edge sampled at cycle 0 → pending at 1 → REQ at 2 → TAKE (out_take high) at 3.
- eret: clears the highest set inservice bit. With inservice = 0, eret is ignored.
- Simultaneous events:
  - eret and REQ→TAKE in the same edge: the eret clear applies first, then the set. Eligibility in that cycle uses the pre-eret inservice.
  - New edge on source sel in the same cycle it is taken: pending[sel] stays 1 (set wins).
  - mtc0 writes to mask or ie take effect at the next edge. elig uses the registered values.
- Nesting: a higher-priority request preempts during service. An equal- or lower-priority request waits until eret.
- ie is not changed by a take; software clears it if required.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: in_irq passes through a 2-flop synchroniser (reset 0) before edge detect. irq_s is the synchronised value; total edge-to-take latency is 5 cycles.
- Undefined: irq_s = in_irq directly; latency is 3 cycles.

Test Plan:
- Reset, then ie=1, in_boundary=1, pulse in_irq[1] → out_take high exactly one cycle at edge+3; out_id=1; out_vector=32'h0000_1010; pending=0; inservice=3'b010.
- ie=1, in_boundary=0: pulse in_irq[0]; out_req high; hold 5 cycles → no take. Raise in_boundary → take next cycle with out_id=0, out_vector=32'h0000_1000.
- Nesting: irq1 in service; pulse irq2 → take id 2, inservice=3'b110. Pulse irq0 → stays pending. First eret → inservice=3'b010; second eret → 0; then irq0 taken.
- Mask drop in REQ: pending[2]=1, out_req=1, write mask=3'b011 → back to IDLE, no take, pending[2] still 1. Restore mask → take id 2.
- Same-cycle edge: new irq1 edge in the REQ→TAKE cycle for id 1 → pending[1]=1 afterwards. A second take of id 1 occurs only after eret.
- Assert in_rst_n low during TAKE → all outputs at reset values immediately. With IRQ_SYNC_EN defined, the first test's take moves to edge+5.
